// File: rtl/tap_select_ctrl.sv
// tap_select_ctrl: streams entropy into a tap selector, retries on byte-budget timeout, then writes the taps to the LFSR.
module tap_select_ctrl #(
  parameter int NUM_OF_TAPS = 15,
  parameter int SIZE        = 32,
  parameter int MAX_BYTES   = 1024,
  parameter int MAX_RETRY   = 3
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     start,
  input  logic                     abort,
  input  logic [7:0]               src_data,
  input  logic                     src_valid,
  output logic                     src_ready,
  output logic                     sel_res,
  output logic                     sel_ena,
  output logic [7:0]               sel_din,
  output logic                     sel_take,
  input  logic [NUM_OF_TAPS*8-1:0] sel_taps,
  input  logic                     sel_done,
  output logic                     cfg_we,
  output logic [7:0]               cfg_addr,
  output logic [7:0]               cfg_data,
  output logic                     lfsr_load,
  output logic                     busy,
  output logic                     cfg_ok,
  output logic                     error,
  output logic [3:0]               retry_cnt
);
  localparam int CW = $clog2(MAX_BYTES + 1);
  if (NUM_OF_TAPS < 1 || NUM_OF_TAPS > 256 || SIZE < 2) begin : g_bad_params
    $error("tap_select_ctrl: unsupported NUM_OF_TAPS/SIZE");
  end
  typedef enum logic [2:0] {IDLE, CLEAR, COLLECT, CAPTURE, WRITE, LOAD, DONE, ERROR} state_t;
  state_t                   state_q;
  logic [3:0]               retry_q;
  logic [CW-1:0]            cnt_q;
  logic [NUM_OF_TAPS*8-1:0] taps_q;
  logic [7:0]               addr_q, data_q;
  logic                     we_q, load_q, clr_q, ena_q, busy_q, ok_q, err_q;
  logic                     coll;
  assign coll      = state_q == COLLECT;
  assign src_ready = coll && !sel_done;
  assign sel_take  = src_valid && src_ready;
  assign sel_din   = coll ? src_data : 8'd0;
  assign sel_res   = clr_q;
  assign sel_ena   = ena_q;
  assign cfg_we    = we_q;
  assign cfg_addr  = addr_q;
  assign cfg_data  = data_q;
  assign lfsr_load = load_q;
  assign busy      = busy_q;
  assign cfg_ok    = ok_q;
  assign error     = err_q;
  assign retry_cnt = retry_q;
  always_ff @(posedge clk) begin
    if (!res) begin
      state_q <= IDLE;
      retry_q <= '0;
      cnt_q   <= '0;
      taps_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      load_q  <= 1'b0;
      clr_q   <= 1'b0;
      ena_q   <= 1'b0;
      busy_q  <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else if (abort && state_q != IDLE) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      load_q  <= 1'b0;
      clr_q   <= 1'b0;
      ena_q   <= 1'b0;
      busy_q  <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE, ERROR: if (start) begin
          state_q <= CLEAR;
          retry_q <= '0;
          clr_q   <= 1'b1;
          busy_q  <= 1'b1;
          ok_q    <= 1'b0;
          err_q   <= 1'b0;
        end
        CLEAR: begin
          state_q <= COLLECT;
          clr_q   <= 1'b0;
          ena_q   <= 1'b1;
          cnt_q   <= '0;
        end
        COLLECT: begin
          if (sel_take && cnt_q != CW'(MAX_BYTES)) cnt_q <= cnt_q + 1'b1;
          // a finishing selector wins over an exhausted byte budget
          if (sel_done) begin
            state_q <= CAPTURE;
            taps_q  <= sel_taps;
            addr_q  <= '0;
            ena_q   <= 1'b0;
          end else if (cnt_q == CW'(MAX_BYTES)) begin
            ena_q <= 1'b0;
            if (retry_q < 4'(MAX_RETRY)) begin
              state_q <= CLEAR;
              retry_q <= retry_q + 4'd1;
              clr_q   <= 1'b1;
            end else begin
              state_q <= ERROR;
              busy_q  <= 1'b0;
              err_q   <= 1'b1;
            end
          end
        end
        CAPTURE: begin
          state_q <= WRITE;
          we_q    <= 1'b1;
          addr_q  <= '0;
          data_q  <= taps_q[7:0];
          taps_q  <= taps_q >> 8;
        end
        WRITE: if (addr_q == 8'(NUM_OF_TAPS - 1)) begin
          state_q <= LOAD;
          we_q    <= 1'b0;
          load_q  <= 1'b1;
        end else begin
          addr_q <= addr_q + 8'd1;
          data_q <= taps_q[7:0];
          taps_q <= taps_q >> 8;
        end
        LOAD: begin
          state_q <= DONE;
          load_q  <= 1'b0;
          busy_q  <= 1'b0;
          ok_q    <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tap_select_ctrl.sv
// tb_tap_select_ctrl: directed bench; instance a has a 64-byte budget, instance b an 8-byte budget.
module tb_tap_select_ctrl;
  localparam int N = 15;
  logic clk = 1'b0, res = 1'b0, abort = 1'b0, start_a = 1'b0, start_b = 1'b0;
  logic [7:0] src_data = 8'd1;
  logic src_valid = 1'b0, toggle = 1'b0, en_done_b = 1'b1;
  logic [N*8-1:0] taps;
  logic src_ready_a, sel_res_a, sel_ena_a, sel_take_a, done_a, cfg_we_a, lfsr_load_a, busy_a, cfg_ok_a, error_a;
  logic src_ready_b, sel_res_b, sel_ena_b, sel_take_b, done_b, cfg_we_b, lfsr_load_b, busy_b, cfg_ok_b, error_b;
  logic [7:0] sel_din_a, cfg_addr_a, cfg_data_a, sel_din_b, cfg_addr_b, cfg_data_b, widx_a = 8'd0, widx_b = 8'd0, lastb = 8'd0;
  logic [3:0] retry_a, retry_b;
  int tcnt_a = 0, tcnt_b = 0, n_take_a = 0, n_hs_a = 0, viol_a = 0, n_we_a = 0, n_we_b = 0, n_load_a = 0, n_load_b = 0;
  int n_clr_a = 0, n_clr_b = 0, wr_err_a = 0, wr_err_b = 0, seq_err = 0;
  int checks = 0, failures = 0, cycle = 0, c0, d0, d1, d2, d3, d4;

  always #5 clk = ~clk;
  for (genvar k = 0; k < N; k++) begin : g_taps
    assign taps[k*8 +: 8] = 8'(k + 1);
  end
  assign done_a = tcnt_a >= 20;
  assign done_b = en_done_b && tcnt_b >= 8;

  tap_select_ctrl #(.NUM_OF_TAPS(N), .SIZE(32), .MAX_BYTES(64), .MAX_RETRY(3)) u_a (
    .clk(clk), .res(res), .start(start_a), .abort(abort), .src_data(src_data), .src_valid(src_valid),
    .src_ready(src_ready_a), .sel_res(sel_res_a), .sel_ena(sel_ena_a), .sel_din(sel_din_a), .sel_take(sel_take_a),
    .sel_taps(taps), .sel_done(done_a), .cfg_we(cfg_we_a), .cfg_addr(cfg_addr_a), .cfg_data(cfg_data_a),
    .lfsr_load(lfsr_load_a), .busy(busy_a), .cfg_ok(cfg_ok_a), .error(error_a), .retry_cnt(retry_a));
  tap_select_ctrl #(.NUM_OF_TAPS(N), .SIZE(32), .MAX_BYTES(8), .MAX_RETRY(3)) u_b (
    .clk(clk), .res(res), .start(start_b), .abort(abort), .src_data(src_data), .src_valid(src_valid),
    .src_ready(src_ready_b), .sel_res(sel_res_b), .sel_ena(sel_ena_b), .sel_din(sel_din_b), .sel_take(sel_take_b),
    .sel_taps(taps), .sel_done(done_b), .cfg_we(cfg_we_b), .cfg_addr(cfg_addr_b), .cfg_data(cfg_data_b),
    .lfsr_load(lfsr_load_b), .busy(busy_b), .cfg_ok(cfg_ok_b), .error(error_b), .retry_cnt(retry_b));

  // selector models and event monitors
  always @(posedge clk) begin
    tcnt_a <= sel_res_a ? 0 : tcnt_a + int'(sel_take_a);
    tcnt_b <= sel_res_b ? 0 : tcnt_b + int'(sel_take_b);
    n_take_a <= n_take_a + int'(sel_take_a);
    n_hs_a <= n_hs_a + int'(src_valid && src_ready_a);
    viol_a <= viol_a + int'(sel_take_a && !src_valid);
    n_clr_a <= n_clr_a + int'(sel_res_a);
    n_clr_b <= n_clr_b + int'(sel_res_b);
    n_load_a <= n_load_a + int'(lfsr_load_a);
    n_load_b <= n_load_b + int'(lfsr_load_b);
    if (sel_take_a || sel_take_b) begin
      if ((sel_take_a ? sel_din_a : sel_din_b) !== lastb + 8'd1) seq_err <= seq_err + 1;
      lastb <= sel_take_a ? sel_din_a : sel_din_b;
    end
  end
  always @(posedge clk) begin
    if (cfg_we_a) begin
      if (cfg_addr_a !== widx_a || cfg_data_a !== widx_a + 8'd1) wr_err_a <= wr_err_a + 1;
      widx_a <= widx_a + 8'd1;
      n_we_a <= n_we_a + 1;
    end else widx_a <= 8'd0;
  end
  always @(posedge clk) begin
    if (cfg_we_b) begin
      if (cfg_addr_b !== widx_b || cfg_data_b !== widx_b + 8'd1) wr_err_b <= wr_err_b + 1;
      widx_b <= widx_b + 8'd1;
      n_we_b <= n_we_b + 1;
    end else widx_b <= 8'd0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // source advances only after a byte was accepted
  task automatic step();
    logic acc;
    #1;
    acc = sel_take_a || sel_take_b;
    @(posedge clk);
    #1;
    if (acc) src_data = src_data + 8'd1;
    if (toggle) src_valid = ~src_valid;
    cycle++;
    #1;
  endtask

  initial begin
    start_a = 1'b1;
    repeat (3) step();
    chk("rst_ctrl_a", {sel_res_a, sel_ena_a, sel_take_a, src_ready_a, cfg_we_a, lfsr_load_a, busy_a, cfg_ok_a, error_a}, 0);
    chk("rst_data_a", {cfg_addr_a, cfg_data_a, sel_din_a, retry_a}, 0);
    chk("rst_ctrl_b", {sel_res_b, sel_ena_b, cfg_we_b, lfsr_load_b, busy_b, cfg_ok_b, error_b, retry_b}, 0);
    res = 1'b1;
    step();
    chk("clear_sel_res", {sel_res_a, sel_ena_a, busy_a}, 3'b101);
    start_a = 1'b0;
    src_valid = 1'b1;
    step();
    chk("collect_entry", {sel_res_a, sel_ena_a, src_ready_a, sel_take_a}, 4'b0111);
    chk("clear_pulses", n_clr_a, 1);
    // normal run
    d0 = n_we_a; d1 = n_take_a;
    for (int i = 0; i < 100 && !done_a; i++) step();
    chk("done_seen", done_a, 1);
    c0 = cycle;
    for (int i = 0; i < 100 && !lfsr_load_a; i++) step();
    chk("load_seen", lfsr_load_a, 1);
    chk("done_to_load", cycle - c0, N + 2);
    chk("norm_writes", n_we_a - d0, N);
    chk("norm_takes", n_take_a - d1, 20);
    step();
    chk("norm_done", {lfsr_load_a, busy_a, cfg_ok_a, error_a, retry_a}, 8'b0010_0000);
    chk("norm_wr_err", wr_err_a, 0);
    // back-pressure run
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk("restart_clear", {sel_res_a, cfg_ok_a, busy_a}, 3'b101);
    toggle = 1'b1;
    d0 = n_take_a; d1 = n_hs_a; d2 = n_we_a;
    for (int i = 0; i < 200 && !lfsr_load_a; i++) step();
    chk("bp_load_seen", lfsr_load_a, 1);
    chk("bp_takes", n_take_a - d0, 20);
    chk("bp_handshakes", n_hs_a - d1, 20);
    chk("bp_take_wo_valid", viol_a, 0);
    chk("bp_writes", n_we_a - d2, N);
    toggle = 1'b0;
    src_valid = 1'b1;
    step();
    chk("bp_done", cfg_ok_a, 1);
    // timeout and retry exhaustion
    en_done_b = 1'b0;
    d0 = n_clr_b; d1 = n_we_b;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    for (int i = 0; i < 200 && !error_b; i++) step();
    chk("to_error", {error_b, busy_b, cfg_ok_b}, 3'b100);
    chk("to_retry", retry_b, 3);
    chk("to_clear_pulses", n_clr_b - d0, 4);
    chk("to_no_writes", n_we_b - d1, 0);
    // done coincides with exhausted budget
    en_done_b = 1'b1;
    d0 = n_clr_b; d1 = n_we_b; d2 = n_load_b;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    chk("col_error_drop", error_b, 0);
    for (int i = 0; i < 100 && !lfsr_load_b; i++) step();
    chk("col_load_seen", lfsr_load_b, 1);
    step();
    chk("col_done", {cfg_ok_b, error_b, retry_b}, 6'b10_0000);
    chk("col_clear_pulses", n_clr_b - d0, 1);
    chk("col_writes", n_we_b - d1, N);
    chk("col_loads", n_load_b - d2, 1);
    chk("col_wr_err", wr_err_b, 0);
    // abort during WRITE
    d0 = n_we_a; d1 = n_load_a;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int i = 0; i < 100 && !(cfg_we_a && cfg_addr_a == 8'd5); i++) step();
    chk("ab_at_addr5", {cfg_we_a, cfg_addr_a}, 9'h105);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_idle", {cfg_we_a, busy_a, sel_ena_a, cfg_ok_a, cfg_addr_a}, 12'h000);
    step();
    chk("ab_writes", n_we_a - d0, 6);
    chk("ab_no_load", n_load_a - d1, 0);
    d0 = n_we_a; d3 = wr_err_a;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int i = 0; i < 100 && !lfsr_load_a; i++) step();
    chk("ab_rerun_load", lfsr_load_a, 1);
    chk("ab_rerun_writes", n_we_a - d0, N);
    chk("ab_rerun_wr_err", wr_err_a - d3, 0);
    step();
    chk("ab_rerun_done", cfg_ok_a, 1);
    d4 = seq_err;
    chk("byte_sequence", d4, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tap_select_ctrl.md
Name: tap_select_ctrl

Overview:
Sequencer that owns one tap selector instance and the LFSR tap-configuration port of the random module.
- On request, clears the selector and streams entropy bytes from the random source into it.
- Watches for selector completion and bounds the attempt with a byte budget, retrying on timeout.
- Writes the captured tap bytes into the LFSR configuration registers one per cycle, then pulses the LFSR load strobe.

Parameters:
NUM_OF_TAPS, 15, number of 8-bit tap entries produced by the selector and written to the LFSR
SIZE, 32, LFSR width; informational, passed through for consistency with the random module
MAX_BYTES, 1024, entropy bytes accepted per attempt before the attempt is declared timed out
MAX_RETRY, 3, number of additional attempts after the first before error

Ports:
clk  in  1  system clock, all logic on rising edge
res  in  1  synchronous, active-low reset
start  in  1  begin configuration; honoured in IDLE, DONE, ERROR
abort  in  1  return to IDLE from any state
src_data  in  8  entropy byte from random source
src_valid  in  1  src_data valid
src_ready  out  1  byte accepted when src_valid && src_ready
sel_res  out  1  selector clear, active high
sel_ena  out  1  selector enable
sel_din  out  8  byte to selector
sel_take  out  1  byte strobe to selector
sel_taps  in  NUM_OF_TAPS*8  selector tap vector, entry k at bits [(k+1)*8-1 -: 8]
sel_done  in  1  selector finished
cfg_we  out  1  LFSR tap register write strobe
cfg_addr  out  8  tap index 0..NUM_OF_TAPS-1
cfg_data  out  8  tap value
lfsr_load  out  1  one-cycle strobe: taps committed
busy  out  1  high in every state except IDLE, DONE, ERROR
cfg_ok  out  1  configuration complete, held in DONE
error  out  1  retries exhausted, held in ERROR
retry_cnt  out  4  retries used in the current run

Behaviour:
- Reset (res=0 at a clk edge) forces IDLE. All outputs become 0: sel_res, sel_ena, sel_take, src_ready, cfg_we, lfsr_load, busy, cfg_ok, error. cfg_addr, cfg_data, sel_din and retry_cnt also become 0. The internal byte counter and tap latch are cleared.
- Reset dominates start and abort. Reset mid-operation abandons the run; no further cfg_we is issued.
- abort (res=1) in any state other than IDLE moves to IDLE on the next edge with the reset output values, except that retry_cnt holds. abort has priority over all other transitions.
- States: IDLE, CLEAR, COLLECT, CAPTURE, WRITE, LOAD, DONE, ERROR.
- IDLE: on start, go to CLEAR and set retry_cnt=0.
- CLEAR: one cycle.
  - sel_res=1, sel_ena=0; byte counter set to 0.
  - Next state is COLLECT.
- COLLECT:
  - sel_ena=1.
  - src_ready = !sel_done, combinational.
  - sel_din = src_data; sel_take = src_valid && src_ready. Both are combinational, so the selector sees a byte in the same cycle it is accepted.
  - Each accepted byte increments the byte counter; the counter saturates at MAX_BYTES.
  - If sel_done=1: latch sel_taps, go to CAPTURE. sel_done has priority over timeout in the same cycle.
  - Else if the counter equals MAX_BYTES: timeout.
    - If retry_cnt < MAX_RETRY: increment retry_cnt and go to CLEAR.
    - Otherwise go to ERROR.
- CAPTURE: one cycle.
  - sel_ena=0, src_ready=0; cfg_addr preset to 0.
  - Next state is WRITE.
- WRITE: exactly NUM_OF_TAPS cycles with cfg_we=1.
  - cfg_addr steps 0,1,…,NUM_OF_TAPS-1.
  - cfg_data = latched tap entry cfg_addr, all 8 bits passed unmodified.
  - After the address NUM_OF_TAPS-1 write, go to LOAD.
- LOAD: one cycle with lfsr_load=1, then DONE.
- DONE: cfg_ok=1 held. start goes to CLEAR with retry_cnt=0; cfg_ok drops on that edge.
- ERROR: error=1 held. start behaves as in DONE.
- start is ignored while busy=1.
- Latency:
  - start edge to first possible sel_take: 2 cycles (CLEAR, then COLLECT).
  - sel_done seen to lfsr_load: NUM_OF_TAPS+2 cycles.
- All outputs except src_ready, sel_din and sel_take are registered.

Test Plan:
- Reset: hold res=0 for 3 cycles with start=1 -> all outputs 0, state IDLE; release res -> CLEAR one cycle later (start still high), sel_res=1 for exactly one cycle.
- Normal run: start, source supplies bytes 0x01,0x02,…; model selector asserts done after 20 accepted bytes with taps entry k = k+1 -> after sel_done, exactly 15 cfg_we cycles with (addr,data)=(0,0x01)…(14,0x0F), then lfsr_load for 1 cycle, cfg_ok=1, retry_cnt=0.
- Back-pressure: src_valid toggled every other cycle -> sel_take only when src_valid=1; byte count equals number of sel_take pulses; no accepted byte is lost or duplicated.
- Timeout/retry: MAX_BYTES=8, selector never done -> sel_res pulses 4 times total, retry_cnt reaches 3, error=1, no cfg_we ever asserted.
- Done/timeout collision: sel_done=1 in the cycle the 8th byte is accepted (MAX_BYTES=8) -> goes to CAPTURE, no retry, normal write sequence follows.
- Abort mid-WRITE: abort at cfg_addr=5 -> cfg_we=0 next cycle, IDLE, no lfsr_load; subsequent start completes a full 15-write run.
